// File: rtl/mfb_protocol_checker.sv
// Passive MFB protocol checker: tracks frames across regions/words and flags
// framing, stall-stability and frame-length violations with sticky/pulse reporting.
module mfb_protocol_checker #(
  parameter int MFB_REGIONS     = 2,
  parameter int MFB_REGION_SIZE = 8,
  parameter int MFB_BLOCK_SIZE  = 8,
  parameter int MFB_ITEM_WIDTH  = 8,
  parameter int MFB_META_WIDTH  = 1,
  parameter int MIN_FRAME_ITEMS = 60,
  parameter int MAX_FRAME_ITEMS = 1500,
  parameter int CNT_WIDTH       = 16,
  localparam int SP = (MFB_REGION_SIZE > 1) ? $clog2(MFB_REGION_SIZE) : 1,
  localparam int EP = $clog2(MFB_REGION_SIZE * MFB_BLOCK_SIZE),
  localparam int RI = MFB_REGION_SIZE * MFB_BLOCK_SIZE
) (
  input  logic                                      CLK,
  input  logic                                      RESET_N,
  input  logic [MFB_REGIONS*RI*MFB_ITEM_WIDTH-1:0]  MON_DATA,
  input  logic [MFB_REGIONS*MFB_META_WIDTH-1:0]     MON_META,
  input  logic [MFB_REGIONS-1:0]                    MON_SOF,
  input  logic [MFB_REGIONS-1:0]                    MON_EOF,
  input  logic [MFB_REGIONS*SP-1:0]                 MON_SOF_POS,
  input  logic [MFB_REGIONS*EP-1:0]                 MON_EOF_POS,
  input  logic                                      MON_SRC_RDY,
  input  logic                                      MON_DST_RDY,
  input  logic                                      CLR_ERR,
  output logic [4:0]                                ERR_PULSE,
  output logic [4:0]                                ERR_VEC,
  output logic                                      ERR_VLD,
  output logic [2:0]                                ERR_FIRST,
  output logic [CNT_WIDTH-1:0]                      ERR_CNT,
  output logic [CNT_WIDTH-1:0]                      FRAME_CNT
);

  localparam int DW = MFB_REGIONS * RI * MFB_ITEM_WIDTH;
  localparam int MW = MFB_REGIONS * MFB_META_WIDTH;
  localparam int LW = $clog2(MAX_FRAME_ITEMS + 2);
  localparam int unsigned MAX_U   = MAX_FRAME_ITEMS;
  localparam int unsigned MIN_U   = MIN_FRAME_ITEMS;
  localparam int unsigned LEN_SAT = MAX_FRAME_ITEMS + 1;
  localparam int unsigned RI_U    = RI;
  localparam int unsigned BS_U    = MFB_BLOCK_SIZE;

  typedef enum logic [2:0] {
    SOF_IN_FRAME = 3'd0,
    EOF_NO_FRAME = 3'd1,
    STALL_CHANGE = 3'd2,
    TOO_LONG     = 3'd3,
    TOO_SHORT    = 3'd4
  } err_code_e;

  logic                   in_frame_q, in_frame_d;
  logic                   long_q, long_d;
  logic [LW-1:0]          len_q, len_d;
  logic                   prev_stall;
  logic [DW-1:0]          prev_data;
  logic [MW-1:0]          prev_meta;
  logic [MFB_REGIONS-1:0] prev_sof, prev_eof;
  logic [MFB_REGIONS*SP-1:0] prev_sof_pos;
  logic [MFB_REGIONS*EP-1:0] prev_eof_pos;
  logic                   xfer, stall_err;
  logic [4:0]             err_c;
  logic [2:0]             first_c;
  logic [CNT_WIDTH-1:0]   frames_c;

  function automatic int unsigned sat(input int unsigned v);
    return (v > LEN_SAT) ? LEN_SAT : v;
  endfunction

  assign xfer = MON_SRC_RDY & MON_DST_RDY;
  assign stall_err = prev_stall && (!MON_SRC_RDY || MON_DATA != prev_data ||
                     MON_META != prev_meta || MON_SOF != prev_sof || MON_EOF != prev_eof ||
                     MON_SOF_POS != prev_sof_pos || MON_EOF_POS != prev_eof_pos);

  always_comb begin
    int unsigned len, s, e;
    logic in_f, lng, sof, eof, eof_first, eof_last;
    in_f      = in_frame_q;
    lng       = long_q;
    len       = 32'(len_q);
    s         = 0;
    e         = 0;
    sof       = 1'b0;
    eof       = 1'b0;
    eof_first = 1'b0;
    eof_last  = 1'b0;
    err_c     = '0;
    frames_c  = '0;
    err_c[STALL_CHANGE] = stall_err;
    if (xfer) begin
      for (int unsigned r = 0; r < MFB_REGIONS; r++) begin
        sof = MON_SOF[r];
        eof = MON_EOF[r];
        s   = 32'(MON_SOF_POS[r*SP +: SP]) * BS_U;
        e   = 32'(MON_EOF_POS[r*EP +: EP]);
        // eof_first: EOF belongs to the frame open before this region's SOF
        eof_first = eof && (!sof || e < s);
        eof_last  = eof && sof && e >= s;
        if (sof && in_f && !eof_first) begin
          err_c[SOF_IN_FRAME] = 1'b1;
          in_f = 1'b0;
        end
        if (eof_first) begin
          if (in_f) begin
            len = sat(len + e + 1);
            if (len > MAX_U && !lng) begin
              err_c[TOO_LONG] = 1'b1;
              lng = 1'b1;
            end
            if (len < MIN_U) err_c[TOO_SHORT] = 1'b1;
            frames_c = frames_c + CNT_WIDTH'(1);
            in_f = 1'b0;
          end else begin
            err_c[EOF_NO_FRAME] = 1'b1;
          end
        end
        if (sof) begin
          lng = 1'b0;
          if (eof_last) begin
            len = sat(e - s + 1);
            if (len < MIN_U) err_c[TOO_SHORT] = 1'b1;
            frames_c = frames_c + CNT_WIDTH'(1);
            in_f = 1'b0;
          end else begin
            len  = sat(RI_U - s);
            in_f = 1'b1;
          end
        end else if (in_f && !eof) begin
          len = sat(len + RI_U);
        end
        if ((sof || in_f) && len > MAX_U && !lng) begin
          err_c[TOO_LONG] = 1'b1;
          lng = 1'b1;
        end
      end
    end
    in_frame_d = in_f;
    long_d     = lng;
    len_d      = LW'(len);
  end

  always_comb begin
    first_c = '0;
    for (int unsigned i = 5; i > 0; i--) begin
      if (err_c[i-1]) first_c = 3'(i - 1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      in_frame_q   <= 1'b0;
      long_q       <= 1'b0;
      len_q        <= '0;
      prev_stall   <= 1'b0;
      prev_data    <= '0;
      prev_meta    <= '0;
      prev_sof     <= '0;
      prev_eof     <= '0;
      prev_sof_pos <= '0;
      prev_eof_pos <= '0;
      ERR_PULSE    <= '0;
      ERR_VEC      <= '0;
      ERR_FIRST    <= '0;
      ERR_CNT      <= '0;
      FRAME_CNT    <= '0;
    end else begin
      in_frame_q   <= in_frame_d;
      long_q       <= long_d;
      len_q        <= len_d;
      prev_stall   <= MON_SRC_RDY & ~MON_DST_RDY;
      prev_data    <= MON_DATA;
      prev_meta    <= MON_META;
      prev_sof     <= MON_SOF;
      prev_eof     <= MON_EOF;
      prev_sof_pos <= MON_SOF_POS;
      prev_eof_pos <= MON_EOF_POS;
      ERR_PULSE    <= err_c;
      FRAME_CNT    <= FRAME_CNT + frames_c;
      // a clear coincident with a new error restarts the record from that error
      if (CLR_ERR) begin
        ERR_VEC   <= err_c;
        ERR_FIRST <= first_c;
        ERR_CNT   <= (|err_c) ? CNT_WIDTH'(1) : '0;
      end else if (|err_c) begin
        ERR_VEC <= ERR_VEC | err_c;
        if (ERR_VEC == '0) ERR_FIRST <= first_c;
        if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + CNT_WIDTH'(1);
      end
    end
  end

  assign ERR_VLD = |ERR_VEC;

endmodule

// File: tb/tb_mfb_protocol_checker.sv
// Directed bench for mfb_protocol_checker with default parameters (RI = 64, 2 regions).
module tb_mfb_protocol_checker;

  localparam int DW = 2 * 64 * 8;

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic [DW-1:0]   MON_DATA;
  logic [1:0]      MON_META;
  logic [1:0]      MON_SOF, MON_EOF;
  logic [5:0]      MON_SOF_POS;
  logic [11:0]     MON_EOF_POS;
  logic            MON_SRC_RDY, MON_DST_RDY, CLR_ERR;
  logic [4:0]      ERR_PULSE, ERR_VEC;
  logic            ERR_VLD;
  logic [2:0]      ERR_FIRST;
  logic [15:0]     ERR_CNT, FRAME_CNT;

  int checks = 0;
  int failures = 0;

  mfb_protocol_checker #(
    .MFB_REGIONS(2), .MFB_REGION_SIZE(8), .MFB_BLOCK_SIZE(8), .MFB_ITEM_WIDTH(8),
    .MFB_META_WIDTH(1), .MIN_FRAME_ITEMS(60), .MAX_FRAME_ITEMS(1500), .CNT_WIDTH(16)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .MON_DATA(MON_DATA), .MON_META(MON_META),
    .MON_SOF(MON_SOF), .MON_EOF(MON_EOF), .MON_SOF_POS(MON_SOF_POS), .MON_EOF_POS(MON_EOF_POS),
    .MON_SRC_RDY(MON_SRC_RDY), .MON_DST_RDY(MON_DST_RDY), .CLR_ERR(CLR_ERR),
    .ERR_PULSE(ERR_PULSE), .ERR_VEC(ERR_VEC), .ERR_VLD(ERR_VLD), .ERR_FIRST(ERR_FIRST),
    .ERR_CNT(ERR_CNT), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle();
    MON_SRC_RDY = 1'b0;
    MON_DST_RDY = 1'b1;
    MON_SOF     = '0;
    MON_EOF     = '0;
    MON_SOF_POS = '0;
    MON_EOF_POS = '0;
  endtask

  task automatic word(input logic [1:0] sof, input logic [1:0] eof,
                      input logic [2:0] sp0, input logic [2:0] sp1,
                      input logic [5:0] ep0, input logic [5:0] ep1);
    MON_SRC_RDY = 1'b1;
    MON_DST_RDY = 1'b1;
    MON_SOF     = sof;
    MON_EOF     = eof;
    MON_SOF_POS = {sp1, sp0};
    MON_EOF_POS = {ep1, ep0};
    tick();
    idle();
  endtask

  task automatic clear();
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
  endtask

  initial begin
    idle();
    MON_DATA = '0;
    MON_META = '0;
    CLR_ERR  = 1'b0;
    tick();
    tick();
    chk("rst_pulse", 32'(ERR_PULSE), 32'h0);
    chk("rst_vec", 32'(ERR_VEC), 32'h0);
    chk("rst_vld", 32'(ERR_VLD), 32'h0);
    chk("rst_first", 32'(ERR_FIRST), 32'h0);
    chk("rst_errcnt", 32'(ERR_CNT), 32'h0);
    chk("rst_framecnt", 32'(FRAME_CNT), 32'h0);
    RESET_N = 1'b1;
    tick();

    // legal 100-item frame across regions, then 64-item single-region frame
    word(2'b01, 2'b10, 3'd0, 3'd0, 6'd0, 6'd35);
    chk("legal100_pulse", 32'(ERR_PULSE), 32'h0);
    chk("legal100_frames", 32'(FRAME_CNT), 32'd1);
    word(2'b01, 2'b01, 3'd0, 3'd0, 6'd63, 6'd0);
    chk("legal64_frames", 32'(FRAME_CNT), 32'd2);
    chk("legal64_vld", 32'(ERR_VLD), 32'h0);

    // SOF inside an open frame: 128 items, abort, reopen at block 2 (48+64), close at e=10
    word(2'b01, 2'b00, 3'd0, 3'd0, 6'd0, 6'd0);
    chk("open_pulse", 32'(ERR_PULSE), 32'h0);
    word(2'b01, 2'b00, 3'd2, 3'd0, 6'd0, 6'd0);
    chk("sofin_pulse", 32'(ERR_PULSE), 32'b00001);
    chk("sofin_first", 32'(ERR_FIRST), 32'd0);
    chk("sofin_frames", 32'(FRAME_CNT), 32'd2);
    chk("sofin_errcnt", 32'(ERR_CNT), 32'd1);
    word(2'b00, 2'b01, 3'd0, 3'd0, 6'd10, 6'd0);
    chk("sofin_pulse_gone", 32'(ERR_PULSE), 32'h0);
    chk("sofin_close_frames", 32'(FRAME_CNT), 32'd3);
    chk("sofin_vec_sticky", 32'(ERR_VEC), 32'b00001);
    clear();
    chk("clr1_vec", 32'(ERR_VEC), 32'h0);
    chk("clr1_errcnt", 32'(ERR_CNT), 32'h0);
    chk("clr1_vld", 32'(ERR_VLD), 32'h0);

    // stall with a data change, then stall with SRC_RDY dropping
    MON_SRC_RDY = 1'b1;
    MON_DST_RDY = 1'b0;
    tick();
    chk("stall_hold_pulse", 32'(ERR_PULSE), 32'h0);
    MON_DATA[0] = ~MON_DATA[0];
    tick();
    chk("stall_data_pulse", 32'(ERR_PULSE), 32'b00100);
    chk("stall_data_errcnt", 32'(ERR_CNT), 32'd1);
    chk("stall_data_first", 32'(ERR_FIRST), 32'd2);
    MON_DST_RDY = 1'b1;
    tick();
    chk("stall_release_pulse", 32'(ERR_PULSE), 32'h0);
    MON_DST_RDY = 1'b0;
    tick();
    MON_SRC_RDY = 1'b0;
    tick();
    chk("stall_srcdrop_pulse", 32'(ERR_PULSE), 32'b00100);
    chk("stall_srcdrop_errcnt", 32'(ERR_CNT), 32'd2);
    idle();
    tick();
    chk("stall_idle_pulse", 32'(ERR_PULSE), 32'h0);
    clear();

    // 40-item frame is too short but still counted
    word(2'b01, 2'b01, 3'd0, 3'd0, 6'd39, 6'd0);
    chk("short_pulse", 32'(ERR_PULSE), 32'b10000);
    chk("short_vec", 32'(ERR_VEC), 32'b10000);
    chk("short_first", 32'(ERR_FIRST), 32'd4);
    chk("short_frames", 32'(FRAME_CNT), 32'd4);

    // 1600-item frame: 128/word, crosses 1500 in word 12 (1408 -> 1536)
    word(2'b01, 2'b00, 3'd0, 3'd0, 6'd0, 6'd0);
    chk("long_w1_pulse", 32'(ERR_PULSE), 32'h0);
    for (int i = 2; i <= 11; i++) begin
      word(2'b00, 2'b00, 3'd0, 3'd0, 6'd0, 6'd0);
      chk("long_mid_pulse", 32'(ERR_PULSE), 32'h0);
    end
    word(2'b00, 2'b00, 3'd0, 3'd0, 6'd0, 6'd0);
    chk("long_cross_pulse", 32'(ERR_PULSE), 32'b01000);
    chk("long_cross_errcnt", 32'(ERR_CNT), 32'd2);
    chk("long_cross_vec", 32'(ERR_VEC), 32'b11000);
    word(2'b00, 2'b01, 3'd0, 3'd0, 6'd63, 6'd0);
    chk("long_close_pulse", 32'(ERR_PULSE), 32'h0);
    chk("long_close_frames", 32'(FRAME_CNT), 32'd5);
    clear();

    // EOF with no frame plus a stall violation in the same cycle
    MON_SRC_RDY = 1'b1;
    MON_DST_RDY = 1'b0;
    tick();
    MON_DST_RDY = 1'b1;
    MON_EOF     = 2'b01;
    MON_EOF_POS = 12'd5;
    tick();
    idle();
    chk("multi_pulse", 32'(ERR_PULSE), 32'b00110);
    chk("multi_vec", 32'(ERR_VEC), 32'b00110);
    chk("multi_first", 32'(ERR_FIRST), 32'd1);
    chk("multi_errcnt", 32'(ERR_CNT), 32'd1);

    // clear coincident with SOF_IN_FRAME keeps only the new error
    word(2'b01, 2'b00, 3'd0, 3'd0, 6'd0, 6'd0);
    chk("clrnew_open_pulse", 32'(ERR_PULSE), 32'h0);
    CLR_ERR = 1'b1;
    word(2'b01, 2'b00, 3'd1, 3'd0, 6'd0, 6'd0);
    CLR_ERR = 1'b0;
    chk("clrnew_vec", 32'(ERR_VEC), 32'b00001);
    chk("clrnew_errcnt", 32'(ERR_CNT), 32'd1);
    chk("clrnew_first", 32'(ERR_FIRST), 32'd0);
    word(2'b00, 2'b01, 3'd0, 3'd0, 6'd63, 6'd0);
    chk("clrnew_close_frames", 32'(FRAME_CNT), 32'd6);
    chk("clrnew_close_pulse", 32'(ERR_PULSE), 32'h0);

    // reset mid-frame discards the frame; a later lone EOF is EOF_NO_FRAME
    word(2'b01, 2'b00, 3'd0, 3'd0, 6'd0, 6'd0);
    RESET_N = 1'b0;
    tick();
    chk("midrst_frames", 32'(FRAME_CNT), 32'd0);
    chk("midrst_vec", 32'(ERR_VEC), 32'h0);
    RESET_N = 1'b1;
    tick();
    word(2'b00, 2'b01, 3'd0, 3'd0, 6'd10, 6'd0);
    chk("midrst_eof_pulse", 32'(ERR_PULSE), 32'b00010);
    chk("midrst_eof_frames", 32'(FRAME_CNT), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
